// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first), oversampled on clk.
// One-word TX holding buffer with valid/ready; framing by ss_n or bit count.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | between frames; arm the next TX word, wait for first rise
// ST_SHIFT | mid-frame; shift miso on fall, sample mosi on rise
// ST_DONE  | last bit sampled; wait for the closing fall
module spi_slave #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_FILL     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int RX_W  = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [RX_W-1:0]         rx_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   hold;
    logic                    hold_full;
    logic                    armed;

    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic [SYNC_STAGES-1:0]  ss_sync;
    logic                    sck_d;

    logic                    sck_s;
    logic                    mosi_s;
    logic                    ss_act;
    logic                    sck_rise;
    logic                    sck_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sck_d     <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_act   = ~ss_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            tx_shift    <= TX_FILL;
            hold        <= '0;
            hold_full   <= 1'b0;
            armed       <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            // Arming is suppressed on the frame-start cycle so an unarmed
            // frame sends TX_FILL and the held word waits for the next one.
            if (state == ST_IDLE && !armed && !(ss_act && sck_rise)) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    armed     <= 1'b1;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift  <= TX_FILL;
                end
            end

            if (!ss_act) begin
                if (state != ST_IDLE)
                    frame_err <= 1'b1;
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sck_rise) begin
                            rx_shift <= RX_W'(mosi_s);
                            bit_cnt  <= CNT_W'(1);
                            state    <= ST_SHIFT;
                            if (armed)
                                armed <= 1'b0;
                            else
                                tx_underrun <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (sck_fall) begin
                            tx_shift <= tx_shift << 1;
                        end else if (sck_rise) begin
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                rx_data  <= {rx_shift, mosi_s};
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= ST_DONE;
                            end else begin
                                rx_shift <= (rx_shift << 1) | RX_W'(mosi_s);
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (sck_fall)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign miso     = tx_shift[DATA_WIDTH-1];
    assign tx_ready = ~hold_full;
    assign busy     = (state != ST_IDLE);

endmodule
